// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared types and constants for the RV32I PC / fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN             = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2,
        S_TRAP = 2'd3
    } fetch_state_e;

    // RV32I without compressed instructions requires word-aligned fetch targets.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-memory request/response bus of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if #(
    parameter int XLEN = 32
) ();

    logic            IMemReq;
    logic [XLEN-1:0] IMemAddr;
    logic            IMemReady;
    logic [31:0]     IMemRdata;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemRdata
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemRdata
    );

endinterface

`default_nettype wire

// File: rtl/pc_next_logic.sv
// ============================================================================
// Module      : pc_next_logic
// Description : PC+4 adder, next-PC select and fetch-target alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_logic
    import pc_fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  wire logic [XLEN-1:0] pc_i,
    input  wire logic            next_src_i,
    input  wire logic [XLEN-1:0] target_i,
    output logic      [XLEN-1:0] pc_plus4_o,
    output logic      [XLEN-1:0] pc_next_o,
    output logic                 misaligned_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Wrap-around at the top of the address space is intentional and legal.
    assign pc_plus4_o   = pc_i + PC_STEP;
    assign pc_next_o    = next_src_i ? target_i : pc_plus4_o;
    assign misaligned_o = is_misaligned(pc_next_o[1:0]);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter and instruction fetch stage of the monocycle core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            PCNextPCSrc,
    input  wire logic [XLEN-1:0] PCTarget,
    input  wire logic            PCCommit,
    pc_fetch_unit_if.master      imem,
    output logic      [31:0]     PCInst,
    output logic                 PCInstValid,
    output logic      [XLEN-1:0] PC,
    output logic      [XLEN-1:0] PCPlus4,
    output logic                 PCMisaligned
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic            req_q;
    logic            valid_q;
    logic            misaligned_q;

    logic [XLEN-1:0] pc_plus4_w;
    logic [XLEN-1:0] pc_d;
    logic            next_misaligned_w;

    pc_next_logic #(
        .XLEN (XLEN)
    ) u_next (
        .pc_i         (pc_q),
        .next_src_i   (PCNextPCSrc),
        .target_i     (PCTarget),
        .pc_plus4_o   (pc_plus4_w),
        .pc_next_o    (pc_d),
        .misaligned_o (next_misaligned_w)
    );

    // Request and valid flags are registered alongside the state so that they
    // track it exactly, including the immediate clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_VECTOR;
            inst_q       <= NOP_INSN;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem.IMemReady) begin
                        inst_q  <= imem.IMemRdata;
                        state_q <= S_EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (PCCommit) begin
                        valid_q <= 1'b0;
                        if (next_misaligned_w) begin
                            misaligned_q <= 1'b1;
                            state_q      <= S_TRAP;
                        end else begin
                            pc_q    <= pc_d;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_TRAP: begin
                    req_q        <= 1'b0;
                    valid_q      <= 1'b0;
                    misaligned_q <= 1'b1;
                end
                default: begin
                    state_q <= S_BOOT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.IMemReq  = req_q;
    assign imem.IMemAddr = pc_q;
    assign PCInst        = inst_q;
    assign PCInstValid   = valid_q;
    assign PC            = pc_q;
    assign PCPlus4       = pc_plus4_w;
    assign PCMisaligned  = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed self-checking bench for the PC / fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        nsrc;
    logic [31:0] target;
    logic        commit;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    logic        rst2;
    logic        nsrc2;
    logic [31:0] target2;
    logic        commit2;
    logic [31:0] inst2;
    logic        inst_valid2;
    logic [31:0] pc2;
    logic [31:0] pc_plus4_2;
    logic        misaligned2;

    int n_checks;
    int n_errors;

    pc_fetch_unit_if #(.XLEN(32)) imem1 ();
    pc_fetch_unit_if #(.XLEN(32)) imem2 ();

    pc_fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .PCNextPCSrc  (nsrc),
        .PCTarget     (target),
        .PCCommit     (commit),
        .imem         (imem1),
        .PCInst       (inst),
        .PCInstValid  (inst_valid),
        .PC           (pc),
        .PCPlus4      (pc_plus4),
        .PCMisaligned (misaligned)
    );

    pc_fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk          (clk),
        .rst          (rst2),
        .PCNextPCSrc  (nsrc2),
        .PCTarget     (target2),
        .PCCommit     (commit2),
        .imem         (imem2),
        .PCInst       (inst2),
        .PCInstValid  (inst_valid2),
        .PC           (pc2),
        .PCPlus4      (pc_plus4_2),
        .PCMisaligned (misaligned2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; nsrc = 1'b0; target = 32'h0; commit = 1'b0;
        imem1.IMemReady = 1'b0; imem1.IMemRdata = 32'h0;
        rst2 = 1'b1; nsrc2 = 1'b0; target2 = 32'h0; commit2 = 1'b0;
        imem2.IMemReady = 1'b0; imem2.IMemRdata = 32'h0;

        // Reset state, still in reset.
        nxt();
        chk("rst_req",   {31'h0, imem1.IMemReq}, 32'h0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_inst",  inst, 32'h0000_0013);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_mis",   {31'h0, misaligned}, 32'h0);

        // Cycle 0 after release is S_BOOT; Ready here must be ignored.
        rst = 1'b0;
        imem1.IMemReady = 1'b1; imem1.IMemRdata = 32'hAAAA_0001; commit = 1'b1;
        #1 chk("boot_req", {31'h0, imem1.IMemReq}, 32'h0);

        nxt(); // cycle 1: S_REQ
        chk("c1_req",  {31'h0, imem1.IMemReq}, 32'h1);
        chk("c1_addr", imem1.IMemAddr, 32'h0);
        chk("c1_inst_boot_ready_ignored", inst, 32'h0000_0013);
        imem1.IMemRdata = 32'h0010_0093;

        nxt(); // cycle 2: S_EXEC
        chk("c2_req",   {31'h0, imem1.IMemReq}, 32'h0);
        chk("c2_valid", {31'h0, inst_valid}, 32'h1);
        chk("c2_inst",  inst, 32'h0010_0093);
        chk("c2_pc4",   pc_plus4, 32'h4);

        nxt(); // cycle 3: S_REQ at 0x4
        chk("c3_req",  {31'h0, imem1.IMemReq}, 32'h1);
        chk("c3_addr", imem1.IMemAddr, 32'h4);
        imem1.IMemRdata = 32'h0020_0113;

        nxt(); // cycle 4: S_EXEC
        chk("c4_inst", inst, 32'h0020_0113);

        nxt(); // cycle 5: S_REQ at 0x8
        chk("c5_req",  {31'h0, imem1.IMemReq}, 32'h1);
        chk("c5_addr", imem1.IMemAddr, 32'h8);
        imem1.IMemRdata = 32'h0030_0193;

        nxt(); // cycle 6: S_EXEC, taken branch to 0x100
        chk("c6_valid", {31'h0, inst_valid}, 32'h1);
        chk("c6_pc4",   pc_plus4, 32'hC);
        nsrc = 1'b1; target = 32'h0000_0100;

        nxt(); // S_REQ at branch target
        chk("br_addr", imem1.IMemAddr, 32'h100);
        chk("br_req",  {31'h0, imem1.IMemReq}, 32'h1);
        nsrc = 1'b0; imem1.IMemRdata = 32'h0040_0213;

        nxt(); // S_EXEC at 0x100
        chk("br_pc4", pc_plus4, 32'h104);
        imem1.IMemReady = 1'b0;

        // Wait states: Ready low three REQ cycles; commit/branch inputs outside EXEC ignored.
        nxt();
        chk("ws0_addr",  imem1.IMemAddr, 32'h104);
        chk("ws0_valid", {31'h0, inst_valid}, 32'h0);
        nsrc = 1'b1; target = 32'h0000_0200; imem1.IMemRdata = 32'hDEAD_BEEF;
        nxt();
        chk("ws1_addr", imem1.IMemAddr, 32'h104);
        chk("ws1_inst", inst, 32'h0040_0213);
        nxt();
        chk("ws2_addr",  imem1.IMemAddr, 32'h104);
        chk("ws2_req",   {31'h0, imem1.IMemReq}, 32'h1);
        chk("ws2_valid", {31'h0, inst_valid}, 32'h0);
        imem1.IMemReady = 1'b1; imem1.IMemRdata = 32'h0050_0293; commit = 1'b0; nsrc = 1'b0;

        nxt(); // S_EXEC, spurious Ready next
        chk("ws_inst",  inst, 32'h0050_0293);
        chk("ws_valid", {31'h0, inst_valid}, 32'h1);
        imem1.IMemRdata = 32'hBAD0_0BAD;

        nxt();
        chk("spur_inst", inst, 32'h0050_0293);
        chk("spur_req",  {31'h0, imem1.IMemReq}, 32'h0);
        commit = 1'b1; nsrc = 1'b1; target = 32'h0000_0102; imem1.IMemReady = 1'b0;

        nxt(); // S_TRAP
        chk("trap_mis",   {31'h0, misaligned}, 32'h1);
        chk("trap_pc",    pc, 32'h104);
        chk("trap_req",   {31'h0, imem1.IMemReq}, 32'h0);
        chk("trap_valid", {31'h0, inst_valid}, 32'h0);
        nsrc = 1'b0; imem1.IMemReady = 1'b1;

        nxt();
        chk("trap_hold_pc",  pc, 32'h104);
        chk("trap_hold_mis", {31'h0, misaligned}, 32'h1);
        chk("trap_hold_req", {31'h0, imem1.IMemReq}, 32'h0);
        rst = 1'b1;

        // Recover, advance to PC=0x4 in S_REQ, then reset asynchronously.
        nxt();
        rst = 1'b0; commit = 1'b1; nsrc = 1'b0; imem1.IMemRdata = 32'h0000_0013;
        #1 chk("rec_mis", {31'h0, misaligned}, 32'h0);
        nxt(); // S_REQ
        nxt(); // S_EXEC
        nxt(); // S_REQ at 0x4
        chk("pre_rst_addr", imem1.IMemAddr, 32'h4);
        chk("pre_rst_req",  {31'h0, imem1.IMemReq}, 32'h1);
        imem1.IMemReady = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_req",   {31'h0, imem1.IMemReq}, 32'h0);
        chk("async_pc",    pc, 32'h0);
        chk("async_valid", {31'h0, inst_valid}, 32'h0);
        chk("async_inst",  inst, 32'h0000_0013);

        // Wrap-around instance.
        nxt();
        chk("wrap_rst_pc",  pc2, 32'hFFFF_FFFC);
        chk("wrap_rst_pc4", pc_plus4_2, 32'h0);
        rst2 = 1'b0; commit2 = 1'b1; imem2.IMemReady = 1'b1; imem2.IMemRdata = 32'h0000_0013;
        nxt();
        chk("wrap_addr0", imem2.IMemAddr, 32'hFFFF_FFFC);
        nxt();
        chk("wrap_valid", {31'h0, inst_valid2}, 32'h1);
        nxt();
        chk("wrap_addr1", imem2.IMemAddr, 32'h0);
        chk("wrap_req",   {31'h0, imem2.IMemReq}, 32'h1);
        chk("wrap_mis",   {31'h0, misaligned2}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the RV32I monocycle core.
- Holds the PC and issues an instruction-memory request.
- Presents the fetched instruction to decode and execute.
- When the core commits the instruction, selects the next PC from PC+4 or the ALU target, using the branch unit's NextPCSrc decision; traps on misaligned targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath and address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCNextPCSrc  in  1  branch unit decision: 1 = take PCTarget, 0 = PC+4.
- PCTarget  in  XLEN  branch/jump target from the ALU.
- PCCommit  in  1  current instruction finished; advance the PC.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  XLEN  fetch address; always equals PC.
- IMemReady  in  1  memory returns data this cycle.
- IMemRdata  in  32  instruction word from memory.
- PCInst  out  32  registered instruction to decode.
- PCInstValid  out  1  PCInst is valid and awaiting commit.
- PC  out  XLEN  current program counter.
- PCPlus4  out  XLEN  PC+4, for JAL/JALR link writeback.
- PCMisaligned  out  1  sticky instruction-address-misaligned trap flag.

Behaviour:
- Reset (async, active-high) forces:
  - state = S_BOOT, PC = RESET_VECTOR, PCInst = 32'h0000_0013 (NOP);
  - IMemReq = 0, PCInstValid = 0, PCMisaligned = 0.
- Outputs change immediately on rst assertion, not at the next edge.
- S_BOOT:
  - IMemReq = 0.
  - Next rising edge after reset release -> S_REQ.
- S_REQ:
  - IMemReq = 1, IMemAddr = PC.
  - Address held stable until IMemReady.
  - On IMemReady = 1: PCInst <= IMemRdata; -> S_EXEC.
  - PCInstValid goes 1 the cycle after Ready.
- S_EXEC:
  - PCInstValid = 1, IMemReq = 0; PCInst held stable.
  - On PCCommit = 1, next = PCNextPCSrc ? PCTarget : PCPlus4.
    - If next[1:0] != 2'b00: PCMisaligned <= 1, PC unchanged, -> S_TRAP.
    - Otherwise: PC <= next, -> S_REQ, with IMemReq = 1 on the following cycle.
- S_TRAP:
  - PCMisaligned = 1, IMemReq = 0, PCInstValid = 0.
  - Held until rst.
- PCPlus4 = PC + 4, truncated to XLEN: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Wrap-around is not a trap.
- PCNextPCSrc and PCTarget are sampled only on a commit cycle in S_EXEC; ignored otherwise.
- IMemReady outside S_REQ is ignored: PCInst is not overwritten.
- PCCommit outside S_EXEC is ignored: no PC change.
- IMemReady in the same cycle as the S_BOOT->S_REQ transition is ignored; only Ready while in S_REQ counts.
- Minimum loop per instruction:
  - REQ with Ready (cycle 0);
  - EXEC with Commit (cycle 1);
  - REQ (cycle 2).
  - Total: 2 cycles per instruction with zero-wait memory.
- Reset mid-fetch or mid-execute aborts the in-flight request and discards PCInst.

Decomposition:
- Package pc_fetch_pkg holds:
  - state enum {S_BOOT, S_REQ, S_EXEC, S_TRAP};
  - NOP_INSN = 32'h0000_0013;
  - default RESET_VECTOR.
- Optional combinational sub-module pc_next_logic:
  - computes PCPlus4, the next-PC mux and the misalign check;
  - instantiated once.
- FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset then zero-wait memory returning 32'h0000_0013, Commit every EXEC cycle, NextPCSrc = 0:
  - IMemAddr sequence is 0x0, 0x4, 0x8;
  - IMemReq high on cycles 1, 3, 5 after release.
- Taken branch: Commit with NextPCSrc = 1, PCTarget = 0x0000_0100:
  - next IMemAddr = 0x100;
  - PCPlus4 = 0x104 during the following EXEC.
- Misaligned target 0x0000_0102, taken:
  - PCMisaligned = 1 next cycle;
  - PC stays at the old value, IMemReq stays 0, Commit is then ignored.
- Wait states, Ready held low 3 cycles:
  - IMemAddr is stable, PCInstValid = 0;
  - PCInst updates only after the Ready cycle; a spurious Ready in EXEC does not change PCInst.
- Wrap: RESET_VECTOR = 32'hFFFF_FFFC, Commit with NextPCSrc = 0:
  - next IMemAddr = 0x0000_0000;
  - no trap.
- Assert rst mid S_REQ with a request pending:
  - IMemReq = 0, PC = RESET_VECTOR, PCInstValid = 0 immediately, before the next clock edge.
